// File: rtl/codec_init_seq.sv
// WM8731 register configuration sequencer: power-up delay, then a fixed 10-entry
// register table written through an I2C master req/ack handshake with retry on failure.
module codec_init_seq #(
  parameter int         POWERUP_WAIT = 1000,
  parameter int         MAX_RETRIES  = 3,
  parameter int         RESP_TIMEOUT = 65535,
  parameter logic [6:0] DEV_ADDR     = 7'h1A
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reinit,
  output logic        i2c_req,
  output logic [6:0]  i2c_addr,
  output logic [15:0] i2c_data,
  input  logic        i2c_ack,
  input  logic        i2c_nack,
  output logic        busy,
  output logic        init_done,
  output logic        init_error
);

  localparam int CNT_MAX = (POWERUP_WAIT > RESP_TIMEOUT) ? POWERUP_WAIT : RESP_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int RTY_W   = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [CNT_W-1:0] PWR_LAST  = CNT_W'(POWERUP_WAIT - 1);
  localparam logic [CNT_W-1:0] RESP_LAST = CNT_W'(RESP_TIMEOUT - 1);
  localparam logic [RTY_W-1:0] RTY_LIM   = RTY_W'(MAX_RETRIES);
  localparam logic [3:0]       LAST_IDX  = 4'd9;

  typedef enum logic [2:0] {
    S_WAIT_PWR  = 3'd0,
    S_LOAD      = 3'd1,
    S_REQ       = 3'd2,
    S_WAIT_RESP = 3'd3,
    S_DONE      = 3'd4,
    S_ERROR     = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       idx;
  logic [RTY_W-1:0] retry;
  logic [CNT_W-1:0] wait_cnt;
  logic             ack_ok, fail, can_retry;

  // Each table word is {reg_addr[6:0], value[8:0]}.
  function automatic logic [15:0] reg_word(input logic [3:0] i);
    case (i)
      4'd0:    reg_word = 16'h1E00;
      4'd1:    reg_word = 16'h0017;
      4'd2:    reg_word = 16'h0217;
      4'd3:    reg_word = 16'h0479;
      4'd4:    reg_word = 16'h0679;
      4'd5:    reg_word = 16'h0812;
      4'd6:    reg_word = 16'h0A00;
      4'd7:    reg_word = 16'h0C00;
      4'd8:    reg_word = 16'h0E0A;
      4'd9:    reg_word = 16'h1201;
      default: reg_word = 16'h0000;
    endcase
  endfunction

  // A simultaneous ack and nack counts as a failure.
  assign ack_ok    = (state_q == S_WAIT_RESP) && i2c_ack && !i2c_nack;
  assign fail      = (state_q == S_WAIT_RESP) && !ack_ok && (i2c_nack || (wait_cnt == RESP_LAST));
  assign can_retry = (retry < RTY_LIM);
  assign i2c_addr  = DEV_ADDR;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_WAIT_PWR;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT_PWR:  if (wait_cnt == PWR_LAST) state_d = S_LOAD;
      S_LOAD:      state_d = S_REQ;
      S_REQ:       state_d = S_WAIT_RESP;
      S_WAIT_RESP: begin
        if (ack_ok)    state_d = (idx == LAST_IDX) ? S_DONE : S_LOAD;
        else if (fail) state_d = can_retry ? S_LOAD : S_ERROR;
      end
      S_DONE,
      S_ERROR:     if (reinit) state_d = S_LOAD;
      default:     state_d = S_WAIT_PWR;
    endcase
  end

  always_comb begin
    busy       = 1'b0;
    init_done  = 1'b0;
    init_error = 1'b0;
    case (state_q)
      S_WAIT_PWR, S_LOAD, S_REQ, S_WAIT_RESP: busy = 1'b1;
      S_DONE:  init_done  = 1'b1;
      S_ERROR: init_error = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // wait_cnt serves both the power-up delay and the response timeout; LOAD clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx      <= '0;
      retry    <= '0;
      wait_cnt <= '0;
      i2c_req  <= 1'b0;
      i2c_data <= '0;
    end else begin
      case (state_q)
        S_WAIT_PWR: wait_cnt <= wait_cnt + 1'b1;
        S_LOAD: begin
          i2c_data <= reg_word(idx);
          wait_cnt <= '0;
        end
        S_REQ: i2c_req <= 1'b1;
        S_WAIT_RESP: begin
          if (ack_ok) begin
            i2c_req <= 1'b0;
            retry   <= '0;
            if (idx != LAST_IDX) idx <= idx + 4'd1;
          end else if (fail) begin
            i2c_req <= 1'b0;
            if (can_retry) retry <= retry + 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_DONE, S_ERROR: begin
          i2c_req <= 1'b0;
          if (reinit) begin
            idx   <= '0;
            retry <= '0;
          end
        end
        default: i2c_req <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_codec_init_seq.sv
// Directed bench for codec_init_seq: full table walk, NACK retry, retry exhaustion,
// response timeout, ack+nack collision, stray responses and mid-transfer reset.
module tb_codec_init_seq;

  localparam int PW = 20;
  localparam int MR = 3;
  localparam int RT = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        reinit = 1'b0;
  logic        i2c_ack = 1'b0;
  logic        i2c_nack = 1'b0;
  logic        i2c_req;
  logic [6:0]  i2c_addr;
  logic [15:0] i2c_data;
  logic        busy, init_done, init_error;

  int passed = 0;
  int total  = 0;

  logic [15:0] exp_tbl [10] = '{16'h1E00, 16'h0017, 16'h0217, 16'h0479, 16'h0679,
                                16'h0812, 16'h0A00, 16'h0C00, 16'h0E0A, 16'h1201};

  codec_init_seq #(
    .POWERUP_WAIT(PW),
    .MAX_RETRIES (MR),
    .RESP_TIMEOUT(RT),
    .DEV_ADDR    (7'h1A)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .reinit    (reinit),
    .i2c_req   (i2c_req),
    .i2c_addr  (i2c_addr),
    .i2c_data  (i2c_data),
    .i2c_ack   (i2c_ack),
    .i2c_nack  (i2c_nack),
    .busy      (busy),
    .init_done (init_done),
    .init_error(init_error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reinit();
    reinit = 1'b1;
    tick();
    reinit = 1'b0;
  endtask

  // Waits for a request, captures its data, then answers 5 cycles after assertion.
  // kind: 0 ack, 1 nack, 2 ack+nack together, 3 no answer.
  task automatic do_req(input int budget, input int kind, output bit got,
                        output int cyc, output logic [15:0] data);
    cyc = 0;
    while (!i2c_req && cyc < budget) begin
      tick();
      cyc++;
    end
    got  = i2c_req;
    data = i2c_data;
    if (got && kind != 3) begin
      repeat (4) tick();
      i2c_ack  = (kind == 0 || kind == 2);
      i2c_nack = (kind == 1 || kind == 2);
      tick();
      i2c_ack  = 1'b0;
      i2c_nack = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    total++; if (i2c_req !== 1'b0) $display("FAIL rst_req: got %b expected 0", i2c_req); else passed++;
    total++; if (i2c_data !== 16'h0000) $display("FAIL rst_data: got %h expected 0000", i2c_data); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL rst_busy: got %b expected 1", busy); else passed++;
    total++; if (init_done !== 1'b0) $display("FAIL rst_done: got %b expected 0", init_done); else passed++;
    total++; if (init_error !== 1'b0) $display("FAIL rst_error: got %b expected 0", init_error); else passed++;
    total++; if (i2c_addr !== 7'h1A) $display("FAIL rst_addr: got %h expected 1a", i2c_addr); else passed++;
    reset = 1'b0;
  endtask

  task automatic test_normal_sequence();
    bit got; int cyc; logic [15:0] d;
    for (int i = 0; i < 10; i++) begin
      do_req(64, 0, got, cyc, d);
      total++; if (!got) $display("FAIL seq_req%0d: got req=0 expected 1", i); else passed++;
      total++; if (d !== exp_tbl[i]) $display("FAIL seq_data%0d: got %h expected %h", i, d, exp_tbl[i]); else passed++;
      total++;
      if (cyc !== ((i == 0) ? PW + 2 : 2))
        $display("FAIL seq_lat%0d: got %0d expected %0d", i, cyc, (i == 0) ? PW + 2 : 2);
      else passed++;
      total++; if (i2c_req !== 1'b0) $display("FAIL seq_drop%0d: got %b expected 0", i, i2c_req); else passed++;
    end
    total++; if (init_done !== 1'b1) $display("FAIL seq_done: got %b expected 1", init_done); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL seq_busy: got %b expected 0", busy); else passed++;
    total++; if (init_error !== 1'b0) $display("FAIL seq_error: got %b expected 0", init_error); else passed++;
  endtask

  task automatic test_nack_retry();
    bit got; int cyc; logic [15:0] d;
    int i = 0, nacks = 0, sends3 = 0, iter = 0, kind;
    pulse_reinit();
    while (i < 10 && iter < 20) begin
      kind = (i == 3 && nacks < 2) ? 1 : 0;
      do_req(64, kind, got, cyc, d);
      total++; if (!got) $display("FAIL nack_req%0d: got req=0 expected 1", i); else passed++;
      if (!got) break;
      total++; if (d !== exp_tbl[i]) $display("FAIL nack_data%0d: got %h expected %h", i, d, exp_tbl[i]); else passed++;
      if (d == 16'h0479) sends3++;
      if (kind == 1) nacks++; else i++;
      iter++;
    end
    total++; if (sends3 !== 3) $display("FAIL nack_sends: got %0d expected 3", sends3); else passed++;
    total++; if (init_done !== 1'b1) $display("FAIL nack_done: got %b expected 1", init_done); else passed++;
    total++; if (init_error !== 1'b0) $display("FAIL nack_error: got %b expected 0", init_error); else passed++;
  endtask

  task automatic test_retry_exhaust();
    bit got; int cyc; int stray; logic [15:0] d;
    pulse_reinit();
    for (int i = 0; i < 5; i++) begin
      do_req(64, 0, got, cyc, d);
      total++; if (d !== exp_tbl[i]) $display("FAIL exh_data%0d: got %h expected %h", i, d, exp_tbl[i]); else passed++;
    end
    for (int a = 0; a <= MR; a++) begin
      do_req(64, 1, got, cyc, d);
      total++; if (d !== 16'h0812) $display("FAIL exh_try%0d: got %h expected 0812", a, d); else passed++;
    end
    total++; if (init_error !== 1'b1) $display("FAIL exh_error: got %b expected 1", init_error); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL exh_busy: got %b expected 0", busy); else passed++;
    total++; if (init_done !== 1'b0) $display("FAIL exh_done: got %b expected 0", init_done); else passed++;
    total++; if (dut.idx !== 4'd5) $display("FAIL exh_idx: got %0d expected 5", dut.idx); else passed++;
    stray = 0;
    repeat (30) begin
      tick();
      if (i2c_req) stray++;
    end
    total++; if (stray !== 0) $display("FAIL exh_quiet: got %0d req cycles expected 0", stray); else passed++;
    pulse_reinit();
    do_req(64, 0, got, cyc, d);
    total++; if (cyc !== 2) $display("FAIL exh_reinit_lat: got %0d expected 2", cyc); else passed++;
    total++; if (d !== 16'h1E00) $display("FAIL exh_reinit_data: got %h expected 1e00", d); else passed++;
    for (int i = 1; i < 10; i++) do_req(64, 0, got, cyc, d);
    total++; if (init_done !== 1'b1) $display("FAIL exh_redone: got %b expected 1", init_done); else passed++;
  endtask

  task automatic test_timeout();
    bit got; int cyc, w; logic [15:0] d;
    pulse_reinit();
    for (int a = 0; a <= MR; a++) begin
      do_req(64, 3, got, cyc, d);
      total++; if (!got) $display("FAIL to_req%0d: got req=0 expected 1", a); else passed++;
      total++; if (d !== 16'h1E00) $display("FAIL to_data%0d: got %h expected 1e00", a, d); else passed++;
      total++; if (cyc !== 2) $display("FAIL to_lat%0d: got %0d expected 2", a, cyc); else passed++;
      w = 0;
      while (i2c_req && w < 100) begin
        tick();
        w++;
      end
      total++; if (w !== RT) $display("FAIL to_width%0d: got %0d expected %0d", a, w, RT); else passed++;
    end
    total++; if (init_error !== 1'b1) $display("FAIL to_error: got %b expected 1", init_error); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL to_busy: got %b expected 0", busy); else passed++;
  endtask

  task automatic test_collision_and_stray();
    bit got; int cyc; logic [15:0] d;
    pulse_reinit();
    do_req(64, 2, got, cyc, d);
    total++; if (d !== 16'h1E00) $display("FAIL col_first: got %h expected 1e00", d); else passed++;
    do_req(64, 0, got, cyc, d);
    total++; if (d !== 16'h1E00) $display("FAIL col_retry: got %h expected 1e00", d); else passed++;
    total++; if (cyc !== 2) $display("FAIL col_lat: got %0d expected 2", cyc); else passed++;
    for (int i = 1; i < 10; i++) do_req(64, 0, got, cyc, d);
    total++; if (init_done !== 1'b1) $display("FAIL col_done: got %b expected 1", init_done); else passed++;
    for (int k = 0; k < 3; k++) begin
      i2c_ack = 1'b1; tick(); i2c_ack = 1'b0; tick();
      i2c_nack = 1'b1; tick(); i2c_nack = 1'b0; tick();
    end
    total++; if (init_done !== 1'b1) $display("FAIL stray_done: got %b expected 1", init_done); else passed++;
    total++; if (i2c_req !== 1'b0) $display("FAIL stray_req: got %b expected 0", i2c_req); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL stray_busy: got %b expected 0", busy); else passed++;
    total++; if (init_error !== 1'b0) $display("FAIL stray_error: got %b expected 0", init_error); else passed++;
  endtask

  task automatic test_reset_mid_transfer();
    bit got; int cyc; logic [15:0] d;
    pulse_reinit();
    for (int i = 0; i < 6; i++) do_req(64, 0, got, cyc, d);
    do_req(64, 3, got, cyc, d);
    total++; if (d !== 16'h0A00) $display("FAIL mid_data: got %h expected 0a00", d); else passed++;
    total++; if (i2c_req !== 1'b1) $display("FAIL mid_req_before: got %b expected 1", i2c_req); else passed++;
    reset = 1'b1;
    #1;
    total++; if (i2c_req !== 1'b0) $display("FAIL mid_req_drop: got %b expected 0", i2c_req); else passed++;
    total++; if (i2c_data !== 16'h0000) $display("FAIL mid_data_clr: got %h expected 0000", i2c_data); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL mid_busy: got %b expected 1", busy); else passed++;
    repeat (3) tick();
    reset = 1'b0;
    do_req(64, 0, got, cyc, d);
    total++; if (cyc !== PW + 2) $display("FAIL mid_restart_lat: got %0d expected %0d", cyc, PW + 2); else passed++;
    total++; if (d !== 16'h1E00) $display("FAIL mid_restart_data: got %h expected 1e00", d); else passed++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", passed, total + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_normal_sequence();
    test_nack_retry();
    test_retry_exhaust();
    test_timeout();
    test_collision_and_stray();
    test_reset_mid_transfer();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
